// File: rtl/rot_addr_gen.sv
// Rotation address generator: walks the source image in raster order, issuing a
// read burst per row segment followed by the writes that place it rotated.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for I_START; rejects bad configurations with O_ERR
// S_SETUP | derives the per-pixel destination stride from the latched config
// S_NEXT  | issues the read for (x,y), or finishes when all rows are done
// S_RD    | read command presented, waiting for acceptance
// S_WR    | write command(s) for the current burst presented
// S_DONE  | O_DONE pulse, O_BUSY low, returning to idle
module rot_addr_gen #(
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int BPP_LOG2  = 0,
  parameter int MAX_BURST = 16,
  parameter int CW        = 5
) (
  input  logic          I_HCLK,
  input  logic          I_HRESET_N,
  input  logic          I_START,
  input  logic [AW-1:0] I_SRC_BASE,
  input  logic [AW-1:0] I_DST_BASE,
  input  logic [DW-1:0] I_WIDTH,
  input  logic [DW-1:0] I_HEIGHT,
  input  logic          I_DIRECTION,
  input  logic [2:0]    I_DEGREES,
  input  logic          I_DMA_READY,
  output logic [AW-1:0] O_ADDR,
  output logic [2:0]    O_SIZE,
  output logic          O_WRITE,
  output logic [CW-1:0] O_COUNT,
  output logic          O_VALID,
  output logic          O_BUSY,
  output logic          O_DONE,
  output logic          O_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_NEXT, S_RD, S_WR, S_DONE} state_t;

  localparam logic [DW-1:0] MAXB_D = DW'(MAX_BURST);
  localparam logic [CW-1:0] MAXB_C = CW'(MAX_BURST);
  localparam logic [AW-1:0] ONE_A  = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, step_q, step_d;
  logic [DW-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [1:0]    rot_q, rot_d;
  logic [CW-1:0] n_q, n_d, k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [1:0]    rot_in;
  logic          start_bad;
  logic [DW-1:0] rem, x_adv;
  logic [CW-1:0] n_c;
  logic [AW-1:0] xa, ya, wa, ha, src_idx, dst_idx, src_addr, dst_addr, step_c;

  assign rot_in    = I_DIRECTION ? (2'd0 - I_DEGREES[1:0]) : I_DEGREES[1:0];
  assign start_bad = (I_WIDTH == '0) || (I_HEIGHT == '0) || I_DEGREES[2];

  assign rem   = w_q - x_q;
  assign n_c   = (rem >= MAXB_D) ? MAXB_C : rem[CW-1:0];
  assign x_adv = x_q + DW'(n_q);

  assign xa = AW'(x_q);
  assign ya = AW'(y_q);
  assign wa = AW'(w_q);
  assign ha = AW'(h_q);

  // Destination index of the first pixel (x,y) of a burst; later pixels of the
  // burst are reached by adding step_q, so no multiply sits on the write path.
  always_comb begin
    src_idx = ya * wa + xa;
    case (rot_q)
      2'd1:    dst_idx = xa * ha + (ha - ONE_A - ya);
      2'd2:    dst_idx = (ha - ONE_A - ya) * wa + (wa - ONE_A - xa);
      2'd3:    dst_idx = (wa - ONE_A - xa) * ha + ya;
      default: dst_idx = src_idx;
    endcase
    case (rot_q)
      2'd1:    step_c = ha << BPP_LOG2;
      2'd2:    step_c = {AW{1'b1}} << BPP_LOG2;
      2'd3:    step_c = ('0 - ha) << BPP_LOG2;
      default: step_c = '0;
    endcase
  end

  assign src_addr = src_q + (src_idx << BPP_LOG2);
  assign dst_addr = dst_q + (dst_idx << BPP_LOG2);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    w_d     = w_q;
    h_d     = h_q;
    rot_d   = rot_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            src_d   = I_SRC_BASE;
            dst_d   = I_DST_BASE;
            w_d     = I_WIDTH;
            h_d     = I_HEIGHT;
            rot_d   = rot_in;
            x_d     = '0;
            y_d     = '0;
            busy_d  = 1'b1;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        step_d  = step_c;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (y_q == h_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = src_addr;
          cnt_d   = n_c;
          n_d     = n_c;
          wr_d    = 1'b0;
          vld_d   = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (I_DMA_READY) begin
          addr_d = dst_addr;
          wr_d   = 1'b1;
          if (rot_q == 2'd0) begin
            cnt_d = n_q;
            k_d   = CW'(1);
          end else begin
            cnt_d = CW'(1);
            k_d   = n_q;
          end
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (I_DMA_READY) begin
          // k_q counts the write commands still owed for this burst
          if (k_q == CW'(1)) begin
            vld_d   = 1'b0;
            state_d = S_NEXT;
            if (x_adv == w_q) begin
              x_d = '0;
              y_d = y_q + DW'(1);
            end else begin
              x_d = x_adv;
            end
          end else begin
            k_d    = k_q - CW'(1);
            addr_d = addr_q + step_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      rot_q   <= '0;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      w_q     <= w_d;
      h_q     <= h_d;
      rot_q   <= rot_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign O_ADDR  = addr_q;
  assign O_SIZE  = 3'(BPP_LOG2);
  assign O_WRITE = wr_q;
  assign O_COUNT = cnt_q;
  assign O_VALID = vld_q;
  assign O_BUSY  = busy_q;
  assign O_DONE  = done_q;
  assign O_ERR   = err_q;

endmodule

// File: tb/tb_rot_addr_gen.sv
// Bench for rot_addr_gen: two instances (1 and 2 bytes per pixel) share stimulus;
// accepted commands are compared with a pixel-mapping reference model.
module tb_rot_addr_gen;

  logic        I_HCLK = 1'b0;
  logic        I_HRESET_N = 1'b1;
  logic        I_START = 1'b0;
  logic [31:0] I_SRC_BASE = '0, I_DST_BASE = '0;
  logic [15:0] I_WIDTH = '0, I_HEIGHT = '0;
  logic        I_DIRECTION = 1'b0;
  logic [2:0]  I_DEGREES = '0;
  logic        I_DMA_READY = 1'b1;

  logic [31:0] addr0, addr1;
  logic [2:0]  size0, size1;
  logic [4:0]  cnt0, cnt1;
  logic        wr0, wr1, vld0, vld1, busy0, busy1, done0, done1, err0, err1;

  always #5 I_HCLK = ~I_HCLK;

  rot_addr_gen #(.AW(32), .DW(16), .BPP_LOG2(0), .MAX_BURST(16), .CW(5)) u_dut0 (
    .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_START(I_START),
    .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE), .I_WIDTH(I_WIDTH),
    .I_HEIGHT(I_HEIGHT), .I_DIRECTION(I_DIRECTION), .I_DEGREES(I_DEGREES),
    .I_DMA_READY(I_DMA_READY), .O_ADDR(addr0), .O_SIZE(size0), .O_WRITE(wr0),
    .O_COUNT(cnt0), .O_VALID(vld0), .O_BUSY(busy0), .O_DONE(done0), .O_ERR(err0));

  rot_addr_gen #(.AW(32), .DW(16), .BPP_LOG2(1), .MAX_BURST(16), .CW(5)) u_dut1 (
    .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_START(I_START),
    .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE), .I_WIDTH(I_WIDTH),
    .I_HEIGHT(I_HEIGHT), .I_DIRECTION(I_DIRECTION), .I_DEGREES(I_DEGREES),
    .I_DMA_READY(I_DMA_READY), .O_ADDR(addr1), .O_SIZE(size1), .O_WRITE(wr1),
    .O_COUNT(cnt1), .O_VALID(vld1), .O_BUSY(busy1), .O_DONE(done1), .O_ERR(err1));

  typedef struct packed {logic wr; logic [31:0] addr; logic [4:0] cnt;} cmd_t;
  typedef cmd_t cmdq_t[$];

  typedef struct {
    logic [31:0] src, dst;
    int          w, h;
    logic        dir;
    logic [2:0]  deg;
    logic        err;
    int          nrd, nwr;
    logic [31:0] first_wr, last_wr;
  } vec_t;

  cmdq_t exp0, exp1, act0, act1;
  int    n_vec = 0, n_err = 0;
  int    done_cnt0 = 0, done_cnt1 = 0;
  logic  st0 = 1'b0, st1 = 1'b0;
  cmd_t  hold0, hold1;
  vec_t  vt[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Accepted commands, stall stability and done pulses, sampled mid-cycle.
  always @(negedge I_HCLK) begin
    if (!I_HRESET_N) begin
      st0 <= 1'b0;
      st1 <= 1'b0;
    end else begin
      if (st0) begin
        check("dut0_hold_valid", vld0, 1);
        check("dut0_hold_fields", {wr0, addr0, cnt0}, hold0);
      end
      if (st1) begin
        check("dut1_hold_valid", vld1, 1);
        check("dut1_hold_fields", {wr1, addr1, cnt1}, hold1);
      end
      if (vld0 && I_DMA_READY) act0.push_back(cmd_t'({wr0, addr0, cnt0}));
      if (vld1 && I_DMA_READY) act1.push_back(cmd_t'({wr1, addr1, cnt1}));
      st0   <= vld0 && !I_DMA_READY;
      st1   <= vld1 && !I_DMA_READY;
      hold0 <= cmd_t'({wr0, addr0, cnt0});
      hold1 <= cmd_t'({wr1, addr1, cnt1});
      if (done0) done_cnt0 <= done_cnt0 + 1;
      if (done1) done_cnt1 <= done_cnt1 + 1;
    end
  end

  // Reference: every source pixel is sent through the rotation formula directly.
  task automatic build(input int bpp, input logic [31:0] src, input logic [31:0] dst,
                       input int w, input int h, input int rot, output cmdq_t q);
    int dw, xp, yp, n;
    logic [31:0] a;
    q  = {};
    dw = (rot == 0 || rot == 2) ? w : h;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x += n) begin
        n = (w - x < 16) ? (w - x) : 16;
        a = src + 32'((y * w + x) << bpp);
        q.push_back(cmd_t'({1'b0, a, 5'(n)}));
        if (rot == 0) begin
          a = dst + 32'((y * dw + x) << bpp);
          q.push_back(cmd_t'({1'b1, a, 5'(n)}));
        end else begin
          for (int k = 0; k < n; k++) begin
            case (rot)
              1:       begin xp = h - 1 - y;       yp = x + k;           end
              2:       begin xp = w - 1 - (x + k); yp = h - 1 - y;       end
              default: begin xp = y;               yp = w - 1 - (x + k); end
            endcase
            a = dst + 32'((yp * dw + xp) << bpp);
            q.push_back(cmd_t'({1'b1, a, 5'd1}));
          end
        end
      end
    end
  endtask

  task automatic cmp_stream(input string nm, input cmdq_t e, input cmdq_t a);
    int   bad = -1;
    cmd_t ge, ga;
    for (int i = 0; i < e.size() && i < a.size(); i++)
      if (bad < 0 && e[i] !== a[i]) bad = i;
    if (bad < 0 && e.size() != a.size()) bad = (e.size() < a.size()) ? e.size() : a.size();
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      ge = (bad < e.size()) ? e[bad] : '0;
      ga = (bad < a.size()) ? a[bad] : '0;
      $display("FAIL %s: cmd %0d got wr=%0d addr=0x%08h cnt=%0d, expected wr=%0d addr=0x%08h cnt=%0d (%0d vs %0d cmds)",
               nm, bad, ga.wr, ga.addr, ga.cnt, ge.wr, ge.addr, ge.cnt, a.size(), e.size());
    end
  endtask

  // Entered and left at posedge+1. rmode: 0 ready always, 1 random, 2 scripted stalls.
  task automatic run_op(input vec_t v, input int rmode, input bit tabled);
    int   rot, c, base0, base1, nrd, nwr;
    bit   fin = 1'b0, busy_seen = 1'b0, got_first = 1'b0;
    logic [31:0] fw, lw, fw1;
    act0 = {};
    act1 = {};
    rot  = v.dir ? (4 - int'(v.deg)) % 4 : int'(v.deg);
    if (!v.err) begin
      build(0, v.src, v.dst, v.w, v.h, rot, exp0);
      build(1, v.src, v.dst, v.w, v.h, rot, exp1);
    end else begin
      exp0 = {};
      exp1 = {};
    end
    base0 = done_cnt0;
    base1 = done_cnt1;
    I_SRC_BASE = v.src; I_DST_BASE = v.dst;
    I_WIDTH = 16'(v.w); I_HEIGHT = 16'(v.h);
    I_DIRECTION = v.dir; I_DEGREES = v.deg;
    I_START = 1'b1;
    @(posedge I_HCLK); #1;
    I_START = 1'b0;
    for (c = 0; c < 30000 && !fin; c++) begin
      case (rmode)
        0:       I_DMA_READY = 1'b1;
        1:       I_DMA_READY = ($urandom_range(0, 3) != 0);
        default: I_DMA_READY = !((c >= 2 && c <= 6) || (c >= 20 && c <= 24));
      endcase
      if (c >= 3 && busy_seen) begin
        I_SRC_BASE = $urandom; I_DST_BASE = $urandom;
        I_WIDTH = 16'($urandom); I_HEIGHT = 16'($urandom);
        I_DIRECTION = 1'($urandom); I_DEGREES = 3'($urandom);
        I_START = (c % 29 == 0);
      end else begin
        I_START = 1'b0;
      end
      @(negedge I_HCLK);
      if (c <= 2) check("first_cmd_latency", vld0, (c == 2) && !v.err);
      if (v.err) begin
        if (c == 0) begin
          check("err_pulse", {err0, err1}, 2'b11);
          check("err_busy", {busy0, busy1}, 2'b00);
        end
        if (c == 1) check("err_one_cycle", {err0, err1}, 2'b00);
        fin = (c == 4);
      end else begin
        busy_seen = busy0;
        if (done0) begin
          check("done_busy_low", {busy0, busy1, done1}, 3'b001);
          fin = 1'b1;
        end
      end
      @(posedge I_HCLK); #1;
    end
    check("op_finished", fin, 1);
    I_START = 1'b0;
    I_DMA_READY = 1'b1;
    repeat (3) @(posedge I_HCLK);
    @(negedge I_HCLK);
    check("done_pulses", done_cnt0 - base0, v.err ? 0 : 1);
    check("done_pulses_bpp2", done_cnt1 - base1, v.err ? 0 : 1);
    check("idle_after", {busy0, vld0, busy1, vld1}, 4'b0000);
    check("size_fields", {size0, size1}, {3'd0, 3'd1});
    @(posedge I_HCLK); #1;
    cmp_stream("dut0_stream", exp0, act0);
    cmp_stream("dut1_stream", exp1, act1);
    if (tabled && !v.err) begin
      nrd = 0; nwr = 0; fw = '0; lw = '0; fw1 = '0;
      foreach (act0[i]) begin
        if (act0[i].wr) begin
          nwr++;
          if (!got_first) fw = act0[i].addr;
          got_first = 1'b1;
          lw = act0[i].addr;
        end else nrd++;
      end
      foreach (act1[i]) if (act1[i].wr && fw1 == '0) fw1 = act1[i].addr;
      check("read_count", nrd, v.nrd);
      check("write_count", nwr, v.nwr);
      check("first_write", fw, v.first_wr);
      check("last_write", lw, v.last_wr);
      if (fw1 != '0) check("first_write_bpp2", fw1, v.dst + ((v.first_wr - v.dst) << 1));
      else           check("first_write_bpp2_present", act1.size(), 0);
    end
  endtask

  initial begin
    vec_t rv;
    vt[0]  = '{32'h1000, 32'h2000, 8, 8, 1'b0, 3'd1, 1'b0, 8, 64, 32'h2007, 32'h2038};
    vt[1]  = '{32'h1000, 32'h2000, 20, 2, 1'b0, 3'd0, 1'b0, 4, 4, 32'h2000, 32'h2024};
    vt[2]  = '{32'h1000, 32'h2000, 4, 3, 1'b1, 3'd1, 1'b0, 3, 12, 32'h2009, 32'h2002};
    vt[3]  = '{32'h1000, 32'h2000, 62, 63, 1'b0, 3'd2, 1'b0, 252, 3906, 32'h2F41, 32'h2000};
    vt[4]  = '{32'h1000, 32'h2000, 8, 8, 1'b0, 3'd5, 1'b1, 0, 0, 32'h0, 32'h0};
    vt[5]  = '{32'h1000, 32'h2000, 0, 8, 1'b0, 3'd1, 1'b1, 0, 0, 32'h0, 32'h0};
    vt[6]  = '{32'h1000, 32'h2000, 5, 0, 1'b1, 3'd3, 1'b1, 0, 0, 32'h0, 32'h0};
    vt[7]  = '{32'h1000, 32'h2000, 3, 5, 1'b1, 3'd2, 1'b0, 5, 15, 32'h200E, 32'h2000};
    vt[8]  = '{32'h1000, 32'h2000, 17, 1, 1'b1, 3'd0, 1'b0, 2, 2, 32'h2000, 32'h2010};
    vt[9]  = '{32'hFFFF_FFF0, 32'hFFFF_FFFE, 1, 3, 1'b0, 3'd3, 1'b0, 3, 3, 32'hFFFF_FFFE, 32'h0};
    vt[10] = '{32'h1000, 32'h2000, 16, 2, 1'b0, 3'd0, 1'b0, 2, 2, 32'h2000, 32'h2010};

    #1 I_HRESET_N = 1'b0;
    repeat (2) @(posedge I_HCLK);
    @(negedge I_HCLK);
    check("reset_outputs", {addr0, cnt0, wr0, vld0, busy0, done0, err0}, '0);
    check("reset_size", {size0, size1}, {3'd0, 3'd1});
    @(posedge I_HCLK); #2 I_HRESET_N = 1'b1;
    @(posedge I_HCLK); #1;

    run_op(vt[0], 2, 1'b1);
    for (int i = 1; i < 11; i++) run_op(vt[i], 1, 1'b1);

    // Reset in the middle of an image, then the same image from scratch.
    I_SRC_BASE = vt[0].src; I_DST_BASE = vt[0].dst;
    I_WIDTH = 16'd8; I_HEIGHT = 16'd8; I_DIRECTION = 1'b0; I_DEGREES = 3'd1;
    I_START = 1'b1;
    @(posedge I_HCLK); #1 I_START = 1'b0;
    repeat (30) @(posedge I_HCLK);
    #2 I_HRESET_N = 1'b0;
    #1;
    check("midreset_dut0", {addr0, cnt0, wr0, vld0, busy0, done0, err0}, '0);
    check("midreset_dut1", {addr1, cnt1, wr1, vld1, busy1, done1, err1}, '0);
    check("midreset_size", {size0, size1}, {3'd0, 3'd1});
    repeat (2) @(posedge I_HCLK);
    #2 I_HRESET_N = 1'b1;
    @(posedge I_HCLK); #1;
    run_op(vt[0], 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rv = '{$urandom, $urandom, int'($urandom_range(1, 20)), int'($urandom_range(1, 12)),
             1'($urandom), 3'($urandom_range(0, 3)), 1'b0, 0, 0, 32'h0, 32'h0};
      run_op(rv, 1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
